// File: rtl/csmulti_accumulator_if.sv
// csmulti_accumulator_if
//   Handshake bundle between the carry save multiplier, the accumulate stage
//   and its downstream consumer.
//   Term side  : in_valid, in_ready, in_product[2*bitsize-1:0], in_last
//   Result side: out_valid, out_ready, out_sum[accwidth-1:0], out_count[7:0],
//                out_ovf
//   slave  modport : the accumulate stage itself
//   master modport : the surrounding logic (term producer + result consumer)
interface csmulti_accumulator_if #(
  parameter int bitsize  = 8,
  parameter int accwidth = 2*bitsize+8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*bitsize-1:0]   in_product;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [accwidth-1:0]    out_sum;
  logic [7:0]             out_count;
  logic                   out_ovf;

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csmulti_accumulator.sv
// csmulti_accumulator
//   Sums a group of unsigned products (group closed by in_last) and presents
//   the group sum, term count (saturating at 255) and an overflow flag.
//   Ports:
//     clk   - single clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - csmulti_accumulator_if.slave (term and result handshakes)
//   Configuration macro:
//     CSMULTI_ACC_SAT_EN - when defined the accumulator saturates to all-ones
//                          on carry-out instead of wrapping.
module csmulti_accumulator #(
  parameter int bitsize  = 8,
  parameter int accwidth = 2*bitsize+8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  csmulti_accumulator_if.slave   bus
);
  localparam int pw = 2*bitsize;

  typedef enum logic {ACC, HOLD} state_t;

  state_t                state_reg, state_next;
  logic [accwidth-1:0]   acc_reg;
  logic [7:0]            cnt_reg;
  logic                  ovf_reg;
  logic [accwidth-1:0]   sum_reg;
  logic [7:0]            count_reg;
  logic                  ovf_out_reg;

  logic                  accept;
  logic                  in_ready_int;
  logic                  out_valid_int;
  logic [accwidth:0]     add_ext;
  logic                  carry;
  logic [accwidth-1:0]   acc_next;
  logic [7:0]            cnt_next;
  logic                  ovf_next;

  // One extra bit on the adder captures the carry-out used for the flag.
  assign add_ext = {1'b0, acc_reg} + {{(accwidth+1-pw){1'b0}}, bus.in_product};
  assign carry   = add_ext[accwidth];

`ifdef CSMULTI_ACC_SAT_EN
  // Once pinned at all-ones, any nonzero term carries again, so the
  // accumulator stays saturated for the rest of the group.
  assign acc_next = carry ? {accwidth{1'b1}} : add_ext[accwidth-1:0];
`else
  assign acc_next = add_ext[accwidth-1:0];
`endif

  assign cnt_next = (cnt_reg == 8'hFF) ? 8'hFF : cnt_reg + 8'd1;
  assign ovf_next = ovf_reg | carry;

  always_comb begin
    state_next    = state_reg;
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      ACC: begin
        // Gated by rst_n so in_ready reads 0 while reset is held.
        in_ready_int = rst_n;
        accept       = bus.in_valid & rst_n;
        if (accept && bus.in_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid_int = 1'b1;
        if (bus.out_ready) begin
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ACC;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      sum_reg     <= '0;
      count_reg   <= '0;
      ovf_out_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (bus.in_last) begin
          // Publish post-add values and start the next group from zero.
          sum_reg     <= acc_next;
          count_reg   <= cnt_next;
          ovf_out_reg <= ovf_next;
          acc_reg     <= '0;
          cnt_reg     <= '0;
          ovf_reg     <= 1'b0;
        end else begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_next;
          ovf_reg <= ovf_next;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_sum   = sum_reg;
  assign bus.out_count = count_reg;
  assign bus.out_ovf   = ovf_out_reg;
endmodule

// File: tb/tb_csmulti_accumulator.sv
// tb_csmulti_accumulator
//   Directed bench: a 24-bit accumulator instance for the functional cases
//   and a 16-bit instance for the overflow / saturation cases.
module tb_csmulti_accumulator;
  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  csmulti_accumulator_if #(.bitsize(8), .accwidth(24)) a_if ();
  csmulti_accumulator_if #(.bitsize(8), .accwidth(16)) b_if ();

  csmulti_accumulator #(.bitsize(8), .accwidth(24)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  csmulti_accumulator #(.bitsize(8), .accwidth(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] p, input logic l);
    a_if.in_valid   = v;
    a_if.in_product = p;
    a_if.in_last    = l;
  endtask

  task automatic drive_b(input logic v, input logic [15:0] p, input logic l);
    b_if.in_valid   = v;
    b_if.in_product = p;
    b_if.in_last    = l;
  endtask

  task automatic check_a(input string tag, input logic [23:0] sum, input logic [7:0] cnt, input logic ovf);
    check({tag, "_valid"}, {31'd0, a_if.out_valid}, 32'd1);
    check({tag, "_sum"},   {8'd0, a_if.out_sum}, {8'd0, sum});
    check({tag, "_count"}, {24'd0, a_if.out_count}, {24'd0, cnt});
    check({tag, "_ovf"},   {31'd0, a_if.out_ovf}, {31'd0, ovf});
    $display("txn %s: sum=0x%0h count=%0d ovf=%0b", tag, a_if.out_sum, a_if.out_count, a_if.out_ovf);
  endtask

  task automatic check_b(input string tag, input logic [15:0] sum, input logic [7:0] cnt, input logic ovf);
    check({tag, "_valid"}, {31'd0, b_if.out_valid}, 32'd1);
    check({tag, "_sum"},   {16'd0, b_if.out_sum}, {16'd0, sum});
    check({tag, "_count"}, {24'd0, b_if.out_count}, {24'd0, cnt});
    check({tag, "_ovf"},   {31'd0, b_if.out_ovf}, {31'd0, ovf});
    $display("txn %s: sum=0x%0h count=%0d ovf=%0b", tag, b_if.out_sum, b_if.out_count, b_if.out_ovf);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    drive_a(1'b0, 16'h0, 1'b0);
    drive_b(1'b0, 16'h0, 1'b0);
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_in_ready",  {31'd0, a_if.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, a_if.out_valid}, 32'd0);
    check("rst_out_sum",   {8'd0, a_if.out_sum}, 32'd0);
    check("rst_out_count", {24'd0, a_if.out_count}, 32'd0);
    check("rst_out_ovf",   {31'd0, a_if.out_ovf}, 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, a_if.in_ready}, 32'd1);

    // Basic group: 0xFF + 0x101 + 0x1 = 0x201
    drive_a(1'b1, 16'h00FF, 1'b0); tick();
    drive_a(1'b1, 16'h0101, 1'b0); tick();
    drive_a(1'b1, 16'h0001, 1'b1); tick();
    check_a("basic", 24'h000201, 8'd3, 1'b0);
    check("basic_hold_in_ready", {31'd0, a_if.in_ready}, 32'd0);
    drive_a(1'b0, 16'h0, 1'b0); tick();
    check("basic_release_valid", {31'd0, a_if.out_valid}, 32'd0);
    check("basic_release_ready", {31'd0, a_if.in_ready}, 32'd1);

    // Single-term group, in_ready low for exactly one cycle
    drive_a(1'b1, 16'hFFFF, 1'b1); tick();
    check_a("single", 24'h00FFFF, 8'd1, 1'b0);
    check("single_in_ready_low", {31'd0, a_if.in_ready}, 32'd0);
    drive_a(1'b0, 16'h0, 1'b0); tick();
    check("single_in_ready_back", {31'd0, a_if.in_ready}, 32'd1);

    // Backpressure: result 7 held for 5 cycles while in_valid stays high
    a_if.out_ready = 1'b0;
    drive_a(1'b1, 16'h0007, 1'b1); tick();
    drive_a(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_a("bp_hold", 24'h000007, 8'd1, 1'b0);
      check("bp_in_ready", {31'd0, a_if.in_ready}, 32'd0);
      tick();
    end
    a_if.out_ready = 1'b1;
    tick();
    check("bp_released", {31'd0, a_if.out_valid}, 32'd0);
    drive_a(1'b1, 16'h0002, 1'b0); tick();
    drive_a(1'b1, 16'h0003, 1'b1); tick();
    check_a("bp_next", 24'h000005, 8'd2, 1'b0);
    drive_a(1'b0, 16'h0, 1'b0); tick();

    // Valid gaps with junk product/last
    drive_a(1'b1, 16'h0004, 1'b0); tick();
    drive_a(1'b0, 16'hBEEF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_no_valid", {31'd0, a_if.out_valid}, 32'd0);
    end
    drive_a(1'b1, 16'h0005, 1'b1); tick();
    check_a("gaps", 24'h000009, 8'd2, 1'b0);
    drive_a(1'b0, 16'h0, 1'b0); tick();

    // Count saturation: 300 terms of 1 -> sum 0x12C, count 255
    for (int i = 0; i < 299; i++) begin
      drive_a(1'b1, 16'h0001, 1'b0); tick();
    end
    drive_a(1'b1, 16'h0001, 1'b1); tick();
    check_a("cnt_sat", 24'h00012C, 8'd255, 1'b0);
    drive_a(1'b0, 16'h0, 1'b0); tick();

    // Overflow on the 16-bit instance: 0xFFFF + 0x0002
    drive_b(1'b1, 16'hFFFF, 1'b0); tick();
    drive_b(1'b1, 16'h0002, 1'b1); tick();
`ifdef CSMULTI_ACC_SAT_EN
    check_b("ovf", 16'hFFFF, 8'd2, 1'b1);
`else
    check_b("ovf", 16'h0001, 8'd2, 1'b1);
`endif
    drive_b(1'b0, 16'h0, 1'b0); tick();
    // Overflow flag must not leak into the next group
    drive_b(1'b1, 16'h0001, 1'b1); tick();
    check_b("ovf_clear", 16'h0001, 8'd1, 1'b0);
    drive_b(1'b0, 16'h0, 1'b0); tick();
    // Terms after the wrap/saturation point: 0xFFFF + 1 + 3
    drive_b(1'b1, 16'hFFFF, 1'b0); tick();
    drive_b(1'b1, 16'h0001, 1'b0); tick();
    drive_b(1'b1, 16'h0003, 1'b1); tick();
`ifdef CSMULTI_ACC_SAT_EN
    check_b("ovf_sticky", 16'hFFFF, 8'd3, 1'b1);
`else
    check_b("ovf_sticky", 16'h0003, 8'd3, 1'b1);
`endif
    drive_b(1'b0, 16'h0, 1'b0); tick();

    // Reset mid-group: outputs (still holding 0x12C/255) clear immediately
    drive_a(1'b1, 16'h0010, 1'b0); tick();
    drive_a(1'b1, 16'h0020, 1'b0); tick();
    drive_a(1'b0, 16'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_sum",      {8'd0, a_if.out_sum}, 32'd0);
    check("midrst_count",    {24'd0, a_if.out_count}, 32'd0);
    check("midrst_in_ready", {31'd0, a_if.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(1'b1, 16'h0003, 1'b1); tick();
    check_a("after_rst", 24'h000003, 8'd1, 1'b0);

    // Reset while in HOLD drops the pending result at once
    drive_a(1'b0, 16'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("holdrst_valid", {31'd0, a_if.out_valid}, 32'd0);
    check("holdrst_sum",   {8'd0, a_if.out_sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
